// File: rtl/iddmm_pkg.sv
// Shared definitions for the IDDMM result drain: default word geometry,
// the drain FSM state encoding and the FIFO count-width helper.
package iddmm_pkg;

  localparam int DEF_K = 256;
  localparam int DEF_N = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } drain_state_t;

  // A FIFO of depth D must represent every occupancy from 0 to D inclusive.
  function automatic int fifo_count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/iddmm_result_drain_if.sv
// Result-path bundle between the IDDMM core, the drain and downstream logic.
// master = core/downstream side, slave = the drain itself.
interface iddmm_result_drain_if #(
  parameter int K      = iddmm_pkg::DEF_K,
  parameter int ADDR_W = $clog2(iddmm_pkg::DEF_N)
);

  logic              fifo_wr_en_a;
  logic [K-1:0]      fifo_wr_data_a;
  logic              fifo_wr_en_sub;
  logic [K-1:0]      fifo_wr_data_sub;
  logic              cal_done;
  logic              cal_sign;
  logic              out_valid;
  logic              out_ready;
  logic [K-1:0]      out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;

  modport master (
    output fifo_wr_en_a, fifo_wr_data_a, fifo_wr_en_sub, fifo_wr_data_sub,
    output cal_done, cal_sign, out_ready,
    input  out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  fifo_wr_en_a, fifo_wr_data_a, fifo_wr_en_sub, fifo_wr_data_sub,
    input  cal_done, cal_sign, out_ready,
    output out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/iddmm_word_fifo.sv
// Show-ahead word FIFO: the oldest word is always presented on head.
// Pushes into a full FIFO are dropped; pops of an empty FIFO are ignored.
module iddmm_word_fifo import iddmm_pkg::*; #(
  parameter  int K     = DEF_K,
  parameter  int DEPTH = 2 * DEF_N,
  localparam int CW    = fifo_count_w(DEPTH),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [K-1:0]  push_data,
  input  logic          pop,
  output logic [K-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [K-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Explicit wrap keeps the pointers correct for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iddmm_result_drain.sv
// Buffers the raw (A) and subtracted (A-P) result streams and, after cal_done,
// emits the one selected by cal_sign LSW first. IDDMM_DRAIN_CHECK_EN enables err.
module iddmm_result_drain import iddmm_pkg::*; #(
  parameter int K      = DEF_K,
  parameter int N      = DEF_N,
  parameter int DEPTH  = 2 * N,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  iddmm_result_drain_if.slave  bus,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int CW = fifo_count_w(DEPTH);

  drain_state_t      state;
  drain_state_t      state_nxt;
  logic              pend;
  logic              pend_sign;
  logic              sel;
  logic [ADDR_W-1:0] idx;
  logic [K-1:0]      head_a;
  logic [K-1:0]      head_sub;
  logic [CW-1:0]     count_a;
  logic [CW-1:0]     count_sub;
  logic              full_a;
  logic              full_sub;
  logic              empty_a;
  logic              empty_sub;
  logic              accept;
  logic              last_accept;
  logic              take_pend;
  logic              counts_ready;
  logic              dup_done;
  logic              unused_flags;

  // Both FIFOs pop on every accept so they stay word-aligned.
  iddmm_word_fifo #(.K(K), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.fifo_wr_en_a),
    .push_data (bus.fifo_wr_data_a),
    .pop       (accept),
    .head      (head_a),
    .count     (count_a),
    .full      (full_a),
    .empty     (empty_a)
  );

  iddmm_word_fifo #(.K(K), .DEPTH(DEPTH)) u_fifo_sub (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.fifo_wr_en_sub),
    .push_data (bus.fifo_wr_data_sub),
    .pop       (accept),
    .head      (head_sub),
    .count     (count_sub),
    .full      (full_sub),
    .empty     (empty_sub)
  );

  assign unused_flags  = empty_a ^ empty_sub;
  assign accept        = bus.out_valid && bus.out_ready;
  assign last_accept   = accept && (idx == ADDR_W'(N - 1));
  assign take_pend     = (state == IDLE) && pend;
  assign counts_ready  = (count_a >= CW'(N)) && (count_sub >= CW'(N));
  assign dup_done      = bus.cal_done && pend && !take_pend;

  assign bus.out_valid = (state == STREAM);
  assign bus.out_data  = bus.out_valid ? (sel ? head_sub : head_a) : '0;
  assign bus.out_idx   = idx;
  assign bus.out_last  = bus.out_valid && (idx == ADDR_W'(N - 1));
  assign busy          = (state != IDLE) || pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend)         state_nxt = WAIT;
      WAIT:    if (counts_ready) state_nxt = STREAM;
      STREAM:  if (last_accept)  state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // A done landing in the same cycle pend is consumed replaces it rather than being lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_sign <= 1'b0;
      sel       <= 1'b0;
    end else begin
      if (take_pend) begin
        sel <= pend_sign;
      end
      if (bus.cal_done && !dup_done) begin
        pend      <= 1'b1;
        pend_sign <= bus.cal_sign;
      end else if (take_pend) begin
        pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (state == WAIT && counts_ready) begin
      idx <= '0;
    end else if (accept) begin
      idx <= last_accept ? '0 : idx + 1'b1;
    end
  end

`ifdef IDDMM_DRAIN_CHECK_EN
  logic err_set;

  assign err_set = (bus.fifo_wr_en_a && full_a) ||
                   (bus.fifo_wr_en_sub && full_sub) ||
                   dup_done ||
                   ((state == WAIT) && counts_ready && (count_a != count_sub));

  // Clearing wins over a simultaneous new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (err_clr) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_check;

  assign err          = 1'b0;
  assign unused_check = ^{err_clr, full_a, full_sub, dup_done};
`endif

endmodule

// File: tb/tb_iddmm_result_drain.sv
// Directed bench for iddmm_result_drain: scoreboard of expected words checked
// on every accepted output, plus timing, stall, error and reset checks.
`timescale 1ns/1ps
module tb_iddmm_result_drain;
  import iddmm_pkg::*;

  localparam int K      = DEF_K;
  localparam int N      = DEF_N;
  localparam int ADDR_W = $clog2(N);
`ifdef IDDMM_DRAIN_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct {
    logic [K-1:0]      data;
    logic [ADDR_W-1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic busy;
  logic err;

  exp_t         exp_q[$];
  logic [K-1:0] qa[$];
  logic [K-1:0] qsub[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic         mon_en = 1'b0;

  logic              stalled = 1'b0;
  logic [K-1:0]      st_data;
  logic [ADDR_W-1:0] st_idx;

  iddmm_result_drain_if #(.K(K), .ADDR_W(ADDR_W)) bus ();

  iddmm_result_drain #(.K(K), .N(N), .DEPTH(2 * N), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .busy    (busy),
    .err     (err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [K-1:0] actual,
                              input logic [K-1:0] expected);
    vectors++;
    assert (actual === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_done(input logic sign);
    for (int i = 0; i < N; i++) begin
      exp_t e;
      logic [K-1:0] a;
      logic [K-1:0] s;
      a = qa.pop_front();
      s = qsub.pop_front();
      e.data = sign ? s : a;
      e.idx  = ADDR_W'(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_result(input logic [K-1:0] base_a, input logic [K-1:0] base_sub,
                              input logic done_last, input logic sign);
    for (int i = 0; i < N; i++) begin
      bus.fifo_wr_en_a     = 1'b1;
      bus.fifo_wr_data_a   = base_a + K'(i);
      bus.fifo_wr_en_sub   = 1'b1;
      bus.fifo_wr_data_sub = base_sub + K'(i);
      qa.push_back(base_a + K'(i));
      qsub.push_back(base_sub + K'(i));
      if (done_last && i == N - 1) begin
        bus.cal_done = 1'b1;
        bus.cal_sign = sign;
      end
      tick();
    end
    bus.fifo_wr_en_a   = 1'b0;
    bus.fifo_wr_en_sub = 1'b0;
    bus.cal_done       = 1'b0;
    if (done_last) model_done(sign);
  endtask

  task automatic apply_a(input logic [K-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.fifo_wr_en_a   = 1'b1;
      bus.fifo_wr_data_a = base + K'(i);
      qa.push_back(base + K'(i));
      tick();
    end
    bus.fifo_wr_en_a = 1'b0;
  endtask

  task automatic apply_sub(input logic [K-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.fifo_wr_en_sub   = 1'b1;
      bus.fifo_wr_data_sub = base + K'(i);
      qsub.push_back(base + K'(i));
      tick();
    end
    bus.fifo_wr_en_sub = 1'b0;
  endtask

  task automatic apply_done(input logic sign, input logic update_model);
    bus.cal_done = 1'b1;
    bus.cal_sign = sign;
    tick();
    bus.cal_done = 1'b0;
    if (update_model) model_done(sign);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      tick();
    end
    check_output({tag, "_left"}, K'(exp_q.size()), '0);
    check_output({tag, "_valid"}, K'(bus.out_valid), '0);
    check_output({tag, "_busy"}, K'(busy), '0);
  endtask

  // Done at edge t: still IDLE after t, WAIT after t+1, streaming after t+2.
  task automatic check_start(input string tag, input logic [K-1:0] first_word);
    check_output({tag, "_busy_t"}, K'(busy), K'(1));
    check_output({tag, "_valid_t"}, K'(bus.out_valid), '0);
    tick();
    check_output({tag, "_valid_t1"}, K'(bus.out_valid), '0);
    tick();
    check_output({tag, "_valid_t2"}, K'(bus.out_valid), K'(1));
    check_output({tag, "_data_t2"}, bus.out_data, first_word);
    check_output({tag, "_idx_t2"}, K'(bus.out_idx), '0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_valid"}, K'(bus.out_valid), '0);
    check_output({tag, "_data"}, bus.out_data, '0);
    check_output({tag, "_idx"}, K'(bus.out_idx), '0);
    check_output({tag, "_last"}, K'(bus.out_last), '0);
    check_output({tag, "_busy"}, K'(busy), '0);
    check_output({tag, "_err"}, K'(err), '0);
  endtask

  // Scoreboard: every accepted word is popped and compared; stalled words must hold.
  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check_output("hold_valid", K'(bus.out_valid), K'(1));
        check_output("hold_data", bus.out_data, st_data);
        check_output("hold_idx", K'(bus.out_idx), K'(st_idx));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_word", K'(bus.out_valid), '0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("out_data", bus.out_data, e.data);
          check_output("out_idx", K'(bus.out_idx), K'(e.idx));
          check_output("out_last", K'(bus.out_last), K'(e.idx == ADDR_W'(N - 1)));
        end
        stalled = 1'b0;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        st_data = bus.out_data;
        st_idx  = bus.out_idx;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    logic found;
    bus.fifo_wr_en_a     = 1'b0;
    bus.fifo_wr_data_a   = '0;
    bus.fifo_wr_en_sub   = 1'b0;
    bus.fifo_wr_data_sub = '0;
    bus.cal_done         = 1'b0;
    bus.cal_sign         = 1'b0;
    bus.out_ready        = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Basic select of the SUB stream with downstream always ready.
    bus.out_ready = 1'b1;
    apply_result(K'('h10), K'('h20), 1'b0, 1'b0);
    apply_done(1'b1, 1'b1);
    check_start("basic", K'('h20));
    wait_drain("basic");

    // Raw stream, done before SUB words exist, ready toggling.
    bus.out_ready = 1'b0;
    apply_a(K'('h10), N);
    apply_done(1'b0, 1'b0);
    repeat (4) tick();
    check_output("wait_valid", K'(bus.out_valid), '0);
    check_output("wait_busy", K'(busy), K'(1));
    apply_sub(K'('h20), N);
    model_done(1'b0);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.out_valid); i++) begin
      bus.out_ready = ~bus.out_ready;
      tick();
    end
    bus.out_ready = 1'b1;
    wait_drain("stall");

    // Done coinciding with the final SUB push.
    apply_result(K'('h100), K'('h200), 1'b1, 1'b1);
    check_start("early", K'('h200));
    wait_drain("early");

    // Second result and its done arrive while the first streams.
    apply_result(K'('h300), K'('h400), 1'b0, 1'b0);
    apply_done(1'b1, 1'b1);
    apply_result(K'('h500), K'('h600), 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready && bus.out_last) begin
        found = 1'b1;
        break;
      end
    end
    check_output("overlap_last_seen", K'(found), K'(1));
    tick();
    check_output("bubble1_valid", K'(bus.out_valid), '0);
    tick();
    check_output("bubble2_valid", K'(bus.out_valid), '0);
    tick();
    check_output("second_valid", K'(bus.out_valid), K'(1));
    check_output("second_data", bus.out_data, K'('h500));
    wait_drain("overlap");

    // Error flag: overflow, duplicate done, clear priority, count mismatch.
    mon_en = 1'b0;
    bus.out_ready = 1'b0;
    apply_a(K'('h700), 2 * N + 1);
    check_output("err_overflow", K'(err), K'(CHK));
    apply_done(1'b0, 1'b0);
    apply_done(1'b0, 1'b0);
    apply_done(1'b0, 1'b0);
    check_output("err_dup_stays", K'(err), K'(CHK));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_output("err_clr", K'(err), '0);
    apply_done(1'b0, 1'b0);
    check_output("err_dup", K'(err), K'(CHK));
    err_clr = 1'b1;
    bus.cal_done = 1'b1;
    tick();
    err_clr = 1'b0;
    bus.cal_done = 1'b0;
    check_output("err_clr_priority", K'(err), '0);
    apply_sub(K'('h800), N);
    tick();
    check_output("err_mismatch", K'(err), K'(CHK));

    rst_n = 1'b0;
    #1;
    check_all_zero("reset_err");
    exp_q.delete();
    qa.delete();
    qsub.delete();
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Reset in the middle of a stream.
    bus.out_ready = 1'b1;
    apply_result(K'('h900), K'('hA00), 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == ADDR_W'(7)) begin
        found = 1'b1;
        break;
      end
    end
    check_output("idx7_seen", K'(found), K'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    mon_en = 1'b0;
    exp_q.delete();
    qa.delete();
    qsub.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check_output("post_reset_busy", K'(busy), '0);
    mon_en = 1'b1;
    apply_result(K'('hB00), K'('hC00), 1'b1, 1'b0);
    check_start("post_reset", K'('hB00));
    wait_drain("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
